// File: rtl/matrix_panel_rx.sv
// Receiver for a serial LED-matrix scan bus: rebuilds full RGB rows and reports framing errors.
// Sizes come from the MATRIX_NUM/MATRIX_SIZE/TOTAL_WIDTH macros; define RX_SEQ_CHECK_EN to enable row-order checking.
`ifndef MATRIX_NUM
`define MATRIX_NUM 4
`endif
`ifndef MATRIX_SIZE
`define MATRIX_SIZE 8
`endif
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH (2*`MATRIX_SIZE)
`endif

// state      | meaning
// RX_IDLE    | no row in progress
// RX_SHIFT   | shifting column bits, bit_cnt counts them
// RX_WAIT_EN | complete row held, waiting for enable fall
// RX_HELD    | row just presented on the outputs
module matrix_panel_rx #(
    parameter int MATRIX_NUM  = `MATRIX_NUM,
    parameter int MATRIX_SIZE = `MATRIX_SIZE,
    parameter int TOTAL_WIDTH = `TOTAL_WIDTH
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              col_shift_clk_i,
    input  logic                              led_latch_i,
    input  logic                              led_en_i,
    input  logic [4:0]                        led_sel_i,
    input  logic [MATRIX_NUM-1:0]             led_r_i,
    input  logic [MATRIX_NUM-1:0]             led_g_i,
    input  logic [MATRIX_NUM-1:0]             led_b_i,
    output logic                              row_valid_o,
    output logic [1:0]                        row_matrix_o,
    output logic [2:0]                        row_idx_o,
    output logic [MATRIX_NUM*TOTAL_WIDTH-1:0] row_r_o,
    output logic [MATRIX_NUM*TOTAL_WIDTH-1:0] row_g_o,
    output logic [MATRIX_NUM*TOTAL_WIDTH-1:0] row_b_o,
    output logic                              frame_done_o,
    output logic                              len_err_o,
    output logic                              seq_err_o,
    output logic [15:0]                       row_count_o
);
    localparam int W   = TOTAL_WIDTH;
    localparam int BUS = MATRIX_NUM * W;
    localparam int CW  = $clog2(W + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_SAT  = CW'(W + 1);
    localparam logic [1:0]    LAST_M   = 2'(MATRIX_NUM - 1);
    localparam logic [2:0]    LAST_R   = 3'(MATRIX_SIZE - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_HELD, RX_WAIT_EN} rx_state_t;

    rx_state_t       state, eff_state, next_state;
    logic [CW-1:0]   bit_cnt, eff_cnt, next_cnt;
    logic            shift_q, latch_q, en_q;
    logic            shift_edge, latch_rise, en_fall;
    logic            dropped, capture, emit, bad_len;
    logic [BUS-1:0]  sr_r, sr_g, sr_b;
    logic [BUS-1:0]  sr_r_upd, sr_g_upd, sr_b_upd;
    logic [BUS-1:0]  hold_r, hold_g, hold_b;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shift_q <= 1'b0;
            latch_q <= 1'b0;
            en_q    <= 1'b1;
        end else begin
            shift_q <= col_shift_clk_i;
            latch_q <= led_latch_i;
            en_q    <= led_en_i;
        end
    end

    assign shift_edge = ~shift_q & col_shift_clk_i;
    assign latch_rise = ~latch_q & led_latch_i;
    assign en_fall    = en_q & ~led_en_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= next_state;
            bit_cnt <= next_cnt;
        end
    end

    // A shift edge is applied before the latch check, so eff_* is the post-shift view.
    always_comb begin
        eff_state  = state;
        eff_cnt    = bit_cnt;
        dropped    = 1'b0;
        if (shift_edge) begin
            if (state == RX_SHIFT) begin
                eff_cnt = (bit_cnt == CNT_SAT) ? bit_cnt : bit_cnt + CW'(1);
            end else begin
                eff_cnt   = CW'(1);
                eff_state = RX_SHIFT;
                dropped   = (state == RX_WAIT_EN);
            end
        end
        next_state = eff_state;
        next_cnt   = eff_cnt;
        case (eff_state)
            RX_SHIFT: begin
                if (latch_rise) begin
                    next_cnt   = '0;
                    next_state = (eff_cnt == CNT_FULL) ? RX_WAIT_EN : RX_IDLE;
                end
            end
            RX_WAIT_EN: if (en_fall) next_state = RX_HELD;
            RX_HELD:    next_state = RX_IDLE;
            default:    next_state = RX_IDLE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        emit    = 1'b0;
        bad_len = dropped;
        case (eff_state)
            RX_IDLE, RX_HELD: if (latch_rise) bad_len = 1'b1;
            RX_SHIFT: begin
                if (latch_rise) begin
                    if (eff_cnt == CNT_FULL) capture = 1'b1;
                    else                     bad_len = 1'b1;
                end
            end
            RX_WAIT_EN: emit = en_fall;
            default: ;
        endcase
    end

    always_comb begin
        sr_r_upd = sr_r;
        sr_g_upd = sr_g;
        sr_b_upd = sr_b;
        if (shift_edge) begin
            for (int m = 0; m < MATRIX_NUM; m++) begin
                sr_r_upd[m*W +: W] = {led_r_i[m], sr_r[m*W+1 +: W-1]};
                sr_g_upd[m*W +: W] = {led_g_i[m], sr_g[m*W+1 +: W-1]};
                sr_b_upd[m*W +: W] = {led_b_i[m], sr_b[m*W+1 +: W-1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sr_r   <= '0;
            sr_g   <= '0;
            sr_b   <= '0;
            hold_r <= '0;
            hold_g <= '0;
            hold_b <= '0;
        end else begin
            sr_r <= sr_r_upd;
            sr_g <= sr_g_upd;
            sr_b <= sr_b_upd;
            if (capture) begin
                hold_r <= sr_r_upd;
                hold_g <= sr_g_upd;
                hold_b <= sr_b_upd;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            row_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            len_err_o    <= 1'b0;
            row_matrix_o <= '0;
            row_idx_o    <= '0;
            row_r_o      <= '0;
            row_g_o      <= '0;
            row_b_o      <= '0;
            row_count_o  <= '0;
        end else begin
            row_valid_o  <= emit;
            frame_done_o <= emit && (led_sel_i[4:3] == LAST_M) && (led_sel_i[2:0] == LAST_R);
            len_err_o    <= bad_len;
            if (emit) begin
                row_matrix_o <= led_sel_i[4:3];
                row_idx_o    <= led_sel_i[2:0];
                row_r_o      <= hold_r;
                row_g_o      <= hold_g;
                row_b_o      <= hold_b;
                row_count_o  <= row_count_o + 16'd1;
            end
        end
    end

`ifdef RX_SEQ_CHECK_EN
    logic       exp_valid;
    logic [1:0] exp_matrix;
    logic [2:0] exp_row;
    logic [1:0] nxt_matrix;
    logic [2:0] nxt_row;

    // Expectation follows the received index, so one bad row yields one error.
    always_comb begin
        nxt_matrix = led_sel_i[4:3] + 2'd1;
        nxt_row    = led_sel_i[2:0];
        if (led_sel_i[4:3] == LAST_M) begin
            nxt_matrix = 2'd0;
            nxt_row    = (led_sel_i[2:0] == LAST_R) ? 3'd0 : led_sel_i[2:0] + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exp_valid  <= 1'b0;
            exp_matrix <= '0;
            exp_row    <= '0;
            seq_err_o  <= 1'b0;
        end else begin
            seq_err_o <= emit && exp_valid &&
                         ({exp_matrix, exp_row} != led_sel_i);
            if (emit) begin
                exp_valid  <= 1'b1;
                exp_matrix <= nxt_matrix;
                exp_row    <= nxt_row;
            end
        end
    end
`else
    assign seq_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_panel_rx.sv
// Scoreboard bench for matrix_panel_rx: stimulus pushes expected rows, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_matrix_panel_rx;
    localparam int N = 4;
    localparam int W = 16;
`ifdef RX_SEQ_CHECK_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b0;
    logic           col_shift_clk_i = 1'b0;
    logic           led_latch_i = 1'b0;
    logic           led_en_i = 1'b1;
    logic [4:0]     led_sel_i = '0;
    logic [N-1:0]   led_r_i = '0, led_g_i = '0, led_b_i = '0;
    logic           row_valid_o, frame_done_o, len_err_o, seq_err_o;
    logic [1:0]     row_matrix_o;
    logic [2:0]     row_idx_o;
    logic [N*W-1:0] row_r_o, row_g_o, row_b_o;
    logic [15:0]    row_count_o;

    matrix_panel_rx dut (
        .clk_i(clk_i), .rst_i(rst_i), .col_shift_clk_i(col_shift_clk_i),
        .led_latch_i(led_latch_i), .led_en_i(led_en_i), .led_sel_i(led_sel_i),
        .led_r_i(led_r_i), .led_g_i(led_g_i), .led_b_i(led_b_i),
        .row_valid_o(row_valid_o), .row_matrix_o(row_matrix_o), .row_idx_o(row_idx_o),
        .row_r_o(row_r_o), .row_g_o(row_g_o), .row_b_o(row_b_o),
        .frame_done_o(frame_done_o), .len_err_o(len_err_o), .seq_err_o(seq_err_o),
        .row_count_o(row_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]     m;
        logic [2:0]     idx;
        logic [N*W-1:0] r, g, b;
        logic           fd, se;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail = 0;
    int len_err_seen = 0;
    int seq_err_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            if (len_err_o) len_err_seen++;
            if (seq_err_o) seq_err_seen++;
            if (frame_done_o && !row_valid_o) chk("frame_done_without_row", 1, 0);
            if (row_valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_row_valid", {59'd0, row_matrix_o, row_idx_o}, 64'hFFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("row_matrix", 64'(row_matrix_o), 64'(e.m));
                    chk("row_idx",    64'(row_idx_o),    64'(e.idx));
                    chk("row_r",      row_r_o,           e.r);
                    chk("row_g",      row_g_o,           e.g);
                    chk("row_b",      row_b_o,           e.b);
                    chk("frame_done", 64'(frame_done_o), 64'(e.fd));
                    chk("seq_err",    64'(seq_err_o),    64'(e.se));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic shift_n(input int n, input logic [N*W-1:0] r, g, b);
        for (int i = 0; i < n; i++) begin
            for (int m = 0; m < N; m++) begin
                led_r_i[m] = r[m*W + (i % W)];
                led_g_i[m] = g[m*W + (i % W)];
                led_b_i[m] = b[m*W + (i % W)];
            end
            col_shift_clk_i = 1'b1;
            tick();
            col_shift_clk_i = 1'b0;
            tick();
        end
    endtask

    task automatic latch();
        led_latch_i = 1'b1;
        tick();
        led_latch_i = 1'b0;
        tick();
    endtask

    task automatic en_pulse(input logic [4:0] sel);
        led_sel_i = sel;
        led_en_i  = 1'b0;
        tick();
        led_en_i  = 1'b1;
        tick();
        tick();
    endtask

    task automatic send_row(input logic [4:0] sel, input logic [N*W-1:0] r, g, b, input logic se);
        exp_t e;
        e.m = sel[4:3]; e.idx = sel[2:0]; e.r = r; e.g = g; e.b = b;
        e.fd = (sel == 5'b11_111);
        e.se = se;
        q.push_back(e);
        shift_n(W, r, g, b);
        latch();
        en_pulse(sel);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    initial begin
        int base_len;
        logic [N*W-1:0] r, g, b;

        // reset values
        tick();
        tick();
        chk("reset_row_valid", 64'(row_valid_o), 0);
        chk("reset_row_count", 64'(row_count_o), 0);
        chk("reset_row_r", row_r_o, 0);
        chk("reset_len_err", 64'(len_err_o), 0);
        rst_i = 1'b1;
        tick();

        // basic row, matrix 1 row 3, red matrix 0 = A5C3
        base_len = len_err_seen;
        send_row(5'b01_011, 64'h1111_2222_3333_A5C3, 64'h0F0F_F0F0_1234_8001,
                 64'hDEAD_BEEF_CAFE_0001, 1'b0);
        chk("basic_row_r0", 64'(row_r_o[15:0]), 64'hA5C3);
        chk("basic_row_count", 64'(row_count_o), 1);
        chk("basic_len_err", 64'(len_err_seen - base_len), 0);

        // short row: 15 bits then latch
        base_len = len_err_seen;
        shift_n(15, 64'h1234_5678_9ABC_DEF0, '0, '0);
        latch();
        en_pulse(5'b00_000);
        chk("short_len_err", 64'(len_err_seen - base_len), 1);
        chk("short_row_count", 64'(row_count_o), 1);

        // long row: 17 bits then latch
        base_len = len_err_seen;
        shift_n(17, 64'h1234_5678_9ABC_DEF0, '1, '0);
        latch();
        en_pulse(5'b00_000);
        chk("long_len_err", 64'(len_err_seen - base_len), 1);
        chk("long_row_count", 64'(row_count_o), 1);

        // reset mid-row, then a clean row
        base_len = len_err_seen;
        shift_n(8, '1, '1, '1);
        do_reset();
        chk("midreset_row_count", 64'(row_count_o), 0);
        send_row(5'b10_101, 64'h0001_0203_0405_0607, 64'h8000_4000_2000_1000,
                 64'h5555_AAAA_3C3C_C3C3, 1'b0);
        chk("midreset_len_err", 64'(len_err_seen - base_len), 0);
        chk("midreset_row_count_after", 64'(row_count_o), 1);

        // full frame in scan order, matrix index fastest
        do_reset();
        base_len = len_err_seen;
        seq_err_seen = 0;
        for (int k = 0; k < 32; k++) begin
            logic [4:0] kk;
            kk = 5'(k);
            r = {16'(k), 16'(k + 100), 16'hFFFF - 16'(k), 16'(k * 3)};
            g = {16'h00FF ^ 16'(k), 16'(k << 4), 16'hA000 | 16'(k), 16'h0F00 + 16'(k)};
            b = {4{16'h1357 + 16'(k)}};
            send_row({kk[1:0], kk[4:2]}, r, g, b, 1'b0);
        end
        chk("frame_row_count", 64'(row_count_o), 32);
        chk("frame_len_err", 64'(len_err_seen - base_len), 0);
        chk("frame_seq_err", 64'(seq_err_seen), 0);

        // out-of-order row: matrix 0, 1, then 3
        send_row(5'b00_000, 64'hAAAA_0000_5555_0001, '0, '1, 1'b0);
        send_row(5'b01_000, 64'hBBBB_1111_6666_0002, '1, '0, 1'b0);
        send_row(5'b11_000, 64'hCCCC_2222_7777_0003, 64'h1, 64'h2, SEQ_ON);

        // pending row dropped by a new shift before enable falls
        base_len = len_err_seen;
        shift_n(W, 64'hFFFF_FFFF_FFFF_FFFF, '0, '0);
        latch();
        send_row(5'b00_001, 64'h9876_5432_10FE_DCBA, 64'h0123_4567_89AB_CDEF,
                 64'h0F1E_2D3C_4B5A_6978, 1'b0);
        chk("drop_len_err", 64'(len_err_seen - base_len), 1);
        chk("final_row_count", 64'(row_count_o), 36);

        repeat (4) tick();
        chk("scoreboard_empty", 64'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
